// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM: instruction fetch and data
// share one access per cycle, with data favoured up to a bounded streak.
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STREAK = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [2:0] STREAK_MAX = 3'(MAX_STREAK);

  logic [2:0] streak;
  logic       streak_hit;
  logic       owner_if;
  logic       owner_d;

  assign streak_hit = (streak == STREAK_MAX);

  // Data wins contention until it has starved fetch for MAX_STREAK grants.
  assign d_gnt  = clr & d_req & (~if_req | ~streak_hit);
  assign if_gnt = clr & if_req & (~d_req | streak_hit);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      streak <= '0;
    end else if (if_gnt || !if_req) begin
      streak <= '0;
    end else if (d_gnt && !streak_hit) begin
      streak <= streak + 3'd1;
    end
  end

  // Stores never produce a response, so only read grants claim the return slot.
  always_ff @(posedge clk) begin
    if (!clr) begin
      owner_if <= 1'b0;
      owner_d  <= 1'b0;
    end else begin
      owner_if <= if_gnt;
      owner_d  <= d_gnt & ~d_we;
    end
  end

  // Gating with clr drops a response whose grant immediately preceded reset.
  assign if_rvalid = owner_if & clr;
  assign d_rvalid  = owner_d & clr;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant priority, streak fairness, read
// response timing, store behaviour and reset handling.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_vectors    = 0;
  int n_miscompare = 0;

  mem_arbiter #(.XLEN(32), .MAX_STREAK(2)) dut (
    .clk       (clk),
    .clr       (clr),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      n_miscompare++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    string order;
    order     = "DDFDDF";
    clr       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;

    next_cycle();
    next_cycle();
    if_req = 1'b1;
    d_req  = 1'b1;
    sample();
    check("rst_if_gnt", if_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_streak", dut.streak, 0);

    // Lone fetch read
    next_cycle();
    clr     = 1'b1;
    d_req   = 1'b0;
    if_addr = 32'h10;
    sample();
    check("f_if_gnt", if_gnt, 1);
    check("f_d_gnt", d_gnt, 0);
    check("f_mem_en", mem_en, 1);
    check("f_mem_addr", mem_addr, 32'h10);
    check("f_mem_we", mem_we, 0);
    next_cycle();
    if_req    = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    sample();
    check("f_if_rvalid", if_rvalid, 1);
    check("f_if_rdata", if_rdata, 32'hDEADBEEF);
    check("f_d_rvalid", d_rvalid, 0);
    check("f_d_rdata", d_rdata, 0);
    check("f_idle_mem_en", mem_en, 0);
    check("f_idle_mem_addr", mem_addr, 0);

    // Lone store
    next_cycle();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h40;
    d_wdata = 32'h1234;
    sample();
    check("st_d_gnt", d_gnt, 1);
    check("st_mem_we", mem_we, 1);
    check("st_mem_wdata", mem_wdata, 32'h1234);
    check("st_mem_addr", mem_addr, 32'h40);
    next_cycle();
    d_req = 1'b0;
    d_we  = 1'b0;
    sample();
    check("st_no_d_rvalid", d_rvalid, 0);
    check("st_no_if_rvalid", if_rvalid, 0);
    check("st_idle_wdata", mem_wdata, 0);
    check("st_idle_we", mem_we, 0);

    // Contention: data twice, then fetch
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h100;
    d_req   = 1'b1;
    d_addr  = 32'h200;
    for (int i = 0; i < 6; i++) begin
      sample();
      check($sformatf("arb%0d_d_gnt", i), d_gnt, order[i] == "D");
      check($sformatf("arb%0d_if_gnt", i), if_gnt, order[i] == "F");
      check($sformatf("arb%0d_addr", i), mem_addr, (order[i] == "D") ? 32'h200 : 32'h100);
      next_cycle();
    end
    if_req = 1'b0;
    d_req  = 1'b0;

    // Back-to-back loads
    next_cycle();
    d_req  = 1'b1;
    d_addr = 32'h0;
    sample();
    check("ld0_d_gnt", d_gnt, 1);
    check("ld0_d_rvalid", d_rvalid, 0);
    next_cycle();
    d_addr    = 32'h4;
    mem_rdata = 32'hA0;
    sample();
    check("ld1_d_gnt", d_gnt, 1);
    check("ld1_d_rvalid", d_rvalid, 1);
    check("ld1_d_rdata", d_rdata, 32'hA0);
    check("ld1_if_rdata", if_rdata, 0);
    next_cycle();
    d_addr    = 32'h8;
    mem_rdata = 32'hA4;
    sample();
    check("ld2_mem_addr", mem_addr, 32'h8);
    check("ld2_d_rvalid", d_rvalid, 1);
    check("ld2_d_rdata", d_rdata, 32'hA4);
    next_cycle();
    d_req     = 1'b0;
    mem_rdata = 32'hA8;
    sample();
    check("ld3_d_rvalid", d_rvalid, 1);
    check("ld3_d_rdata", d_rdata, 32'hA8);
    next_cycle();
    sample();
    check("ld4_d_rvalid", d_rvalid, 0);

    // Reset right after a fetch grant
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h20;
    sample();
    check("rr_if_gnt", if_gnt, 1);
    next_cycle();
    clr       = 1'b0;
    mem_rdata = 32'h55;
    sample();
    check("rr_if_rvalid", if_rvalid, 0);
    check("rr_if_rdata", if_rdata, 0);
    check("rr_if_gnt_off", if_gnt, 0);
    check("rr_mem_en", mem_en, 0);
    check("rr_mem_addr", mem_addr, 0);
    next_cycle();
    sample();
    check("rr_streak", dut.streak, 0);
    check("rr_if_rvalid2", if_rvalid, 0);
    next_cycle();
    clr     = 1'b1;
    if_addr = 32'h24;
    sample();
    check("rr_regnt", if_gnt, 1);
    check("rr_regnt_addr", mem_addr, 32'h24);
    next_cycle();
    if_req    = 1'b0;
    mem_rdata = 32'h77;
    sample();
    check("rr_rvalid", if_rvalid, 1);
    check("rr_rdata", if_rdata, 32'h77);

    // Fetch withdraws after stalling behind data
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h300;
    d_req   = 1'b1;
    d_addr  = 32'h400;
    sample();
    check("wd_d_gnt", d_gnt, 1);
    check("wd_if_gnt", if_gnt, 0);
    next_cycle();
    if_req = 1'b0;
    d_addr = 32'h404;
    sample();
    check("wd_streak1", dut.streak, 1);
    check("wd_if_gnt2", if_gnt, 0);
    check("wd_mem_addr", mem_addr, 32'h404);
    next_cycle();
    d_req = 1'b0;
    sample();
    check("wd_streak0", dut.streak, 0);
    check("wd_if_rvalid", if_rvalid, 0);
    check("wd_mem_en", mem_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the address and data width.
REQ-002 The block SHALL have parameter MAX_STREAK, default 2, giving the maximum consecutive data grants while fetch waits; legal range 1-7.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port if_req, input, 1 bit: instruction-fetch read request.
REQ-006 The block SHALL have port if_addr, input, XLEN bits: fetch address.
REQ-007 The block SHALL have port if_gnt, output, 1 bit: fetch request accepted this cycle.
REQ-008 The block SHALL have port if_rvalid, output, 1 bit: fetch read data valid.
REQ-009 The block SHALL have port if_rdata, output, XLEN bits: fetch read data.
REQ-010 The block SHALL have port d_req, input, 1 bit: data load/store request.
REQ-011 The block SHALL have port d_we, input, 1 bit: 1 for store, 0 for load.
REQ-012 The block SHALL have port d_addr, input, XLEN bits: data address.
REQ-013 The block SHALL have port d_wdata, input, XLEN bits: store data.
REQ-014 The block SHALL have port d_gnt, output, 1 bit: data request accepted this cycle.
REQ-015 The block SHALL have port d_rvalid, output, 1 bit: load data valid.
REQ-016 The block SHALL have port d_rdata, output, XLEN bits: load data.
REQ-017 The block SHALL have port mem_en, output, 1 bit: single-port RAM access strobe.
REQ-018 The block SHALL have port mem_we, output, 1 bit: RAM write enable.
REQ-019 The block SHALL have port mem_addr, output, XLEN bits: RAM address.
REQ-020 The block SHALL have port mem_wdata, output, XLEN bits: RAM write data.
REQ-021 The block SHALL have port mem_rdata, input, XLEN bits: RAM read data, valid one cycle after a read strobe.

Function
REQ-022 The block SHALL drive grants combinationally each cycle, at most one grant per cycle; if_gnt and d_gnt are never both high.
REQ-023 The block SHALL give the grant to the lone requester when only one req is high; with no req, no grant, mem_en=0, mem_we=0.
REQ-024 The block SHALL grant data when both are high, unless streak==MAX_STREAK, in which case it grants fetch.
REQ-025 The block SHALL update the 3-bit streak register as follows: +1 on a d_gnt while if_req is high (saturating at MAX_STREAK); cleared on if_gnt or whenever if_req is low.
REQ-026 The block SHALL drive the granted requester's address on mem_addr with mem_en=1 in the grant cycle; for data it also drives mem_we=d_we and mem_wdata=d_wdata; for fetch, mem_we=0.
REQ-027 The block SHALL hold mem_addr, mem_wdata and mem_we at 0 in cycles with no grant.
REQ-028 The block SHALL register the response owner for every read grant (fetch, or data with d_we=0).
REQ-029 The block SHALL, exactly one cycle after a read grant, assert the owner's rvalid for one cycle with rdata=mem_rdata.
REQ-030 The block SHALL hold the non-owner's rvalid at 0 and its rdata at 0.
REQ-031 The block SHALL NOT produce an rvalid for stores; a store completes in its grant cycle.
REQ-032 The block SHALL accept a new grant in the same cycle as the previous response, giving full throughput of one access per cycle.
REQ-033 Requesters SHALL hold req, addr, we and wdata stable until gnt; the block SHALL tolerate req dropping before gnt, which is treated as withdrawn with no access.
REQ-034 The block SHALL have no internal request queue; latency is 0 cycles to grant when uncontended and 1 cycle from grant to rvalid.

Reset
REQ-035 The block SHALL, when clr=0 at a rising edge, clear streak and the response-owner registers; if_rvalid=0 and d_rvalid=0 the following cycle.
REQ-036 The block SHALL force if_gnt, d_gnt, mem_en and mem_we to 0 while clr=0, and SHALL NOT start any access.
REQ-037 The block SHALL drop a read granted in the cycle before reset assertion: no rvalid is produced.

Verification
REQ-038 The bench SHALL check: if_req=1 alone, if_addr=0x10, mem_rdata=0xDEADBEEF next cycle -> if_gnt same cycle, mem_addr=0x10, if_rvalid next cycle with if_rdata=0xDEADBEEF.
REQ-039 The bench SHALL check: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x1234 -> d_gnt, mem_we=1, mem_wdata=0x1234, no d_rvalid in the following cycle.
REQ-040 The bench SHALL check: both req held high for 6 cycles with MAX_STREAK=2 -> grant order D,D,F,D,D,F.
REQ-041 The bench SHALL check: back-to-back loads to 0x0,0x4,0x8 -> d_rvalid high for 3 consecutive cycles starting 1 cycle after the first grant, with data in order.
REQ-042 The bench SHALL check: fetch read granted, clr=0 the next edge -> no if_rvalid, all outputs 0, streak 0; after clr=1 a new request is granted normally.
REQ-043 The bench SHALL check: if_req drops after 1 stalled cycle behind data -> streak cleared, no fetch access issued.
